audio_i2s_transmitter: RTL and testbench
========================================

Name: audio_i2s_transmitter

Overview:
- Sink-side counterpart to the APU sample mixer: accepts the 9-bit unsigned mixed sample stream through a valid/ready handshake and buffers it in a small FIFO.
- Converts each sample to 16-bit two's complement and serialises it as a standard I2S stereo frame (same word on left and right) toward an external audio DAC.
- Generates BCLK and LRCLK itself (it is the bus master).
- Reports frame boundaries and underruns back to the sample producer.

Parameters:
- BCLK_DIV, 2: system clocks per BCLK half-period; legal range >= 1.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two, >= 2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sample  in  9  unsigned mixed sample, midpoint 256.
- i_valid  in  1  i_sample valid this cycle.
- o_ready  out  1  FIFO can accept; high when FIFO not full.
- o_bclk  out  1  I2S bit clock.
- o_lrclk  out  1  I2S word select; 0 = left, 1 = right.
- o_sdata  out  1  I2S serial data, MSB first.
- o_frame_stb  out  1  one-cycle pulse when a new frame word is loaded.
- o_underrun  out  1  one-cycle pulse when a frame loads while the FIFO is empty.

Behaviour:
- Reset (async assert, sync release effect):
  - o_bclk = 0, o_lrclk = 0, o_sdata = 0, o_frame_stb = 0, o_underrun = 0.
  - FIFO empty, so o_ready = 1.
  - Divider count = 0, bit_idx = 31, frame word = 16'h0000.
- Handshake:
  - A push occurs on any cycle with i_valid && o_ready.
  - o_ready is combinational from FIFO count (!full); it does not depend on i_valid.
  - While o_ready = 0, i_valid is ignored and the sample is not stored; the producer must hold or drop it.
- Divider:
  - The counter runs 0..BCLK_DIV-1.
  - At terminal count it wraps to 0 and o_bclk toggles.
  - A falling-edge event is the cycle in which o_bclk toggles from 1 to 0.
  - Each BCLK period is 2*BCLK_DIV clocks; each frame is 64*BCLK_DIV clocks.
- Frame sequencer (on each falling-edge event, registered into the same cycle's outputs):
  - bit_idx <= bit_idx + 1, mod 32.
  - o_lrclk <= 1 when the new bit_idx is in 15..30; otherwise 0. LRCLK therefore changes one BCLK before each channel's MSB, per I2S.
  - o_sdata <= word[15 - new bit_idx] for new bit_idx 0..15, and word[31 - new bit_idx] for 16..31.
- Frame load (falling-edge event where the new bit_idx = 0):
  - If the FIFO is non-empty: pop the head, set word = {~s[8], s[7:0], 7'b0}, and pulse o_frame_stb.
  - If the FIFO is empty: word is unchanged (the last sample repeats), and both o_frame_stb and o_underrun pulse.
  - Bit 0 sdata uses the newly loaded word in the same cycle.
  - Conversion examples: 256 -> 16'h0000, 0 -> 16'h8000, 511 -> 16'h7F80.
- Simultaneous push and pop:
  - Emptiness for the pop decision uses the count before this cycle's push; there is no bypass.
  - Push into an empty FIFO on a load cycle therefore gives an underrun, and the pushed sample is stored.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: all state returns immediately to reset values and queued samples are discarded. The first load occurs on the first falling-edge event after release, i.e. 2*BCLK_DIV clocks after reset deassertion.
- FIFO contents are not reset-cleared; only the pointers and count are.

Test Plan:
- Reset, BCLK_DIV=2, no input -> o_bclk toggles every 2 clocks; o_frame_stb and o_underrun pulse every 128 clocks; o_sdata stays 0.
- Push a single 511 at reset release -> first frame shifts 16'h7F80 MSB-first on left (lrclk = 0) and again on right (lrclk = 1); o_underrun = 0 on that load.
- Push 0, then 256 back-to-back -> frame 1 carries 16'h8000 on both channels, frame 2 carries 16'h0000; o_lrclk rises at bit_idx 15 and falls at 31.
- Hold i_valid = 1 with incrementing samples -> o_ready falls after 4 accepted samples; one sample accepted per frame thereafter; output order matches accepted order with no loss or duplication.
- Starve after one sample (value 300) -> the next frame repeats 16'h1600 with an o_underrun pulse coincident with o_frame_stb.
- Assert i_rst_n low mid-right-channel with 3 samples queued -> all outputs 0 and o_ready = 1 immediately; after release, the first load is an underrun with word 16'h0000.

Source files
------------

// File: rtl/audio_i2s_transmitter.sv
// I2S stereo transmitter: buffers 9-bit unsigned samples in a small FIFO and
// serialises each one as a 16-bit two's complement word on both channels.
module audio_i2s_transmitter #(
   parameter int BCLK_DIV   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [8:0] i_sample,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_bclk,
   output logic       o_lrclk,
   output logic       o_sdata,
   output logic       o_frame_stb,
   output logic       o_underrun
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(BCLK_DIV - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   function automatic logic [15:0] to_pcm16(input logic [8:0] s);
      return {~s[8], s[7:0], 7'b0000000};
   endfunction

   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             bclk_q, bclk_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [15:0]      word_q, word_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic             stb_q, stb_d;
   logic             urun_q, urun_d;

   logic             push_s;
   logic             pop_s;
   logic             fall_s;
   logic             load_s;
   logic [4:0]       new_idx_s;

   assign o_ready     = (count_q != FIFO_FULL);
   assign o_bclk      = bclk_q;
   assign o_lrclk     = lrclk_q;
   assign o_sdata     = sdata_q;
   assign o_frame_stb = stb_q;
   assign o_underrun  = urun_q;

   // Next-state logic: divider, frame sequencer, FIFO pointers.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      div_d     = div_q;
      bclk_d    = bclk_q;
      bit_idx_d = bit_idx_q;
      word_d    = word_q;
      lrclk_d   = lrclk_q;
      sdata_d   = sdata_q;
      stb_d     = 1'b0;
      urun_d    = 1'b0;

      push_s    = i_valid && (count_q != FIFO_FULL);
      fall_s    = (div_q == DIV_TC) && bclk_q;
      new_idx_s = bit_idx_q + 5'd1;
      load_s    = fall_s && (new_idx_s == 5'd0);
      // Emptiness is judged before this cycle's push: no bypass path.
      pop_s     = load_s && (count_q != {CNT_W{1'b0}});

      if (div_q == DIV_TC) begin
         div_d  = {DIV_W{1'b0}};
         bclk_d = ~bclk_q;
      end else begin
         div_d  = div_q + DIV_W'(1);
      end

      if (fall_s) begin
         bit_idx_d = new_idx_s;
         lrclk_d   = (new_idx_s >= 5'd15) && (new_idx_s <= 5'd30);
         if (load_s) begin
            stb_d = 1'b1;
            if (pop_s) begin
               word_d = to_pcm16(mem_q[rd_ptr_q]);
            end else begin
               urun_d = 1'b1;
            end
         end else begin
            word_d = word_q;
         end
         // Both channels carry the same word, so the bit index folds mod 16.
         sdata_d = word_d[4'd15 - new_idx_s[3:0]];
      end else begin
         bit_idx_d = bit_idx_q;
      end

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q  <= {PTR_W{1'b0}};
         rd_ptr_q  <= {PTR_W{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         div_q     <= {DIV_W{1'b0}};
         bclk_q    <= 1'b0;
         bit_idx_q <= 5'd31;
         word_q    <= 16'h0000;
         lrclk_q   <= 1'b0;
         sdata_q   <= 1'b0;
         stb_q     <= 1'b0;
         urun_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         bit_idx_q <= bit_idx_d;
         word_q    <= word_d;
         lrclk_q   <= lrclk_d;
         sdata_q   <= sdata_d;
         stb_q     <= stb_d;
         urun_q    <= urun_d;
      end
   end

   // Sample storage; contents survive reset, only pointers are cleared.
   always_ff @(posedge i_clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= i_sample;
      end
   end

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Scoreboard bench: tests queue expected frame words, a monitor deserialises
// the I2S stream and checks each frame against the queue.
module tb_audio_i2s_transmitter;

   localparam int BD = 2;
   localparam int FD = 4;
   localparam int FRAME = 64 * BD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] sample = 9'd0;
   logic       valid = 1'b0;
   logic       ready, bclk, lrclk, sdata, frame_stb, underrun;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [15:0] w;
      logic        ur;
   } exp_t;
   exp_t exp_q[$];

   audio_i2s_transmitter #(.BCLK_DIV(BD), .FIFO_DEPTH(FD)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample), .i_valid(valid),
      .o_ready(ready), .o_bclk(bclk), .o_lrclk(lrclk), .o_sdata(sdata),
      .o_frame_stb(frame_stb), .o_underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [15:0] w, input logic ur);
      exp_t e;
      e.w = w;
      e.ur = ur;
      exp_q.push_back(e);
   endtask

   task automatic assert_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic edge_step(inout int e);
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bclk"}, 32'(bclk), 32'd0);
      check({tag, "_lrclk"}, 32'(lrclk), 32'd0);
      check({tag, "_sdata"}, 32'(sdata), 32'd0);
      check({tag, "_stb"}, 32'(frame_stb), 32'd0);
      check({tag, "_urun"}, 32'(underrun), 32'd0);
      check({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   // Monitor: pop on each frame strobe, collect 32 bits on BCLK rising edges.
   initial begin
      exp_t        cur;
      logic [31:0] word;
      logic [31:0] lr;
      int          nbits;
      logic        active;
      logic        bclk_prev;
      active = 1'b0;
      bclk_prev = 1'b0;
      nbits = 0;
      word = 32'd0;
      lr = 32'd0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            bclk_prev = 1'b0;
         end else begin
            if (frame_stb) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame actual=strobe required=none");
                  active = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  check("underrun_flag", 32'(underrun), 32'(cur.ur));
                  active = 1'b1;
                  nbits = 0;
                  word = 32'd0;
                  lr = 32'd0;
               end
            end
            if (active && bclk && !bclk_prev) begin
               word = {word[30:0], sdata};
               lr[nbits] = lrclk;
               nbits++;
               if (nbits == 32) begin
                  check("frame_word", word, {cur.w, cur.w});
                  check("lrclk_pattern", lr, 32'h7FFF8000);
                  active = 1'b0;
               end
            end
            bclk_prev = bclk;
         end
      end
   end

   initial begin
      int e;
      int nacc;
      int acc_edge[7];
      logic r;

      // Reset state
      #1;
      check_reset_outputs("rst0");

      // Idle: underrun frames of silence, BCLK period 2*BD
      expect_frame(16'h0000, 1'b1);
      expect_frame(16'h0000, 1'b1);
      release_reset();
      e = 0;
      for (int k = 1; k <= 8; k++) begin
         edge_step(e);
         check("bclk_toggle", 32'(bclk), 32'((k / 2) % 2));
      end
      repeat (2 * FRAME + 3 - e) @(posedge clk);

      // Single 511 pushed at release, then repeated with underrun
      assert_reset();
      expect_frame(16'h7F80, 1'b0);
      expect_frame(16'h7F80, 1'b1);
      release_reset();
      e = 0;
      valid = 1'b1;
      sample = 9'd511;
      edge_step(e);
      valid = 1'b0;
      repeat (2 * FRAME + 3 - e) @(posedge clk);

      // 0 then 256 back-to-back
      assert_reset();
      expect_frame(16'h8000, 1'b0);
      expect_frame(16'h0000, 1'b0);
      release_reset();
      e = 0;
      valid = 1'b1;
      sample = 9'd0;
      edge_step(e);
      sample = 9'd256;
      edge_step(e);
      valid = 1'b0;
      repeat (2 * FRAME + 3 - e) @(posedge clk);

      // Starve after 300
      assert_reset();
      expect_frame(16'h1600, 1'b0);
      expect_frame(16'h1600, 1'b1);
      release_reset();
      e = 0;
      valid = 1'b1;
      sample = 9'd300;
      edge_step(e);
      valid = 1'b0;
      repeat (2 * FRAME + 3 - e) @(posedge clk);

      // Backpressure: hold valid with incrementing samples
      assert_reset();
      expect_frame(16'h0000, 1'b1);
      expect_frame(16'h8080, 1'b0);
      expect_frame(16'h8100, 1'b0);
      expect_frame(16'h8180, 1'b0);
      expect_frame(16'h8200, 1'b0);
      expect_frame(16'h8280, 1'b0);
      expect_frame(16'h8300, 1'b0);
      expect_frame(16'h8380, 1'b0);
      release_reset();
      e = 0;
      repeat (4) edge_step(e);
      nacc = 0;
      valid = 1'b1;
      sample = 9'd1;
      while (nacc < 7 && e < 8 * FRAME) begin
         r = ready;
         edge_step(e);
         if (r) begin
            acc_edge[nacc] = e;
            nacc++;
            sample = sample + 9'd1;
            if (nacc == 4) check("ready_full", 32'(ready), 32'd0);
         end
      end
      valid = 1'b0;
      check("accepted_count", 32'(nacc), 32'd7);
      check("accept4_edge", 32'(acc_edge[3]), 32'd8);
      check("accept5_edge", 32'(acc_edge[4]), 32'd133);
      check("accept6_edge", 32'(acc_edge[5]), 32'd261);
      repeat (8 * FRAME + 3 - e) @(posedge clk);

      // Reset mid right channel with 3 samples queued
      assert_reset();
      expect_frame(16'h8500, 1'b0);
      release_reset();
      e = 0;
      valid = 1'b1;
      sample = 9'd10;
      edge_step(e);
      sample = 9'd20;
      edge_step(e);
      sample = 9'd30;
      edge_step(e);
      sample = 9'd40;
      edge_step(e);
      valid = 1'b0;
      repeat (96) edge_step(e);
      check("mid_lrclk_right", 32'(lrclk), 32'd1);
      check("mid_ready_before", 32'(ready), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      expect_frame(16'h0000, 1'b1);
      release_reset();
      repeat (FRAME + 3) @(posedge clk);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
